// File: rtl/xilinx_distram_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_distram_sync_fifo
// Purpose  : Single-clock FIFO built on a per-bit dual-port distributed LUT
//            RAM (write through port A, read through DPRA/DPO) followed by a
//            registered output. Provides pointer management, occupancy count
//            and registered full/empty/almost flags computed from the
//            next-cycle count.
// Options  : Define XILINX_DISTRAM_SYNC_FIFO_ERR_EN to add the registered
//            WRERR/RDERR rejected-request pulses.
// Revision : 1.0 - initial release
// ============================================================================
module xilinx_distram_sync_fifo #(
    parameter int ADDR_WIDTH          = 6,
    parameter int DATA_WIDTH          = 8,
    parameter int ALMOST_FULL_OFFSET  = 2,
    parameter int ALMOST_EMPTY_OFFSET = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  WREN,
    input  logic                  RDEN,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOSTFULL,
    output logic                  ALMOSTEMPTY,
    output logic [ADDR_WIDTH:0]   COUNT
`ifdef XILINX_DISTRAM_SYNC_FIFO_ERR_EN
    ,
    output logic                  WRERR,
    output logic                  RDERR
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_depth      = 1 << ADDR_WIDTH;
    // Depths 16 and 32 both land in a 32-entry primitive; the unused upper
    // address bit is tied low by zero-extending the pointer.
    localparam int c_prim_aw    = (ADDR_WIDTH <= 5) ? 5 : ADDR_WIDTH;
    localparam int c_prim_depth = 1 << c_prim_aw;

    localparam logic [ADDR_WIDTH:0]   c_cnt_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_full_cnt  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_af_thresh = c_full_cnt - (ADDR_WIDTH+1)'(ALMOST_FULL_OFFSET);
    localparam logic [ADDR_WIDTH:0]   c_ae_thresh = (ADDR_WIDTH+1)'(ALMOST_EMPTY_OFFSET);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    generate
        if (ADDR_WIDTH < 4 || ADDR_WIDTH > 7) begin : g_bad_addr_width
            $error("xilinx_distram_sync_fifo: ADDR_WIDTH must be 4..7");
        end
        if (DATA_WIDTH < 1) begin : g_bad_data_width
            $error("xilinx_distram_sync_fifo: DATA_WIDTH must be >= 1");
        end
        if (ALMOST_FULL_OFFSET < 1 || ALMOST_FULL_OFFSET > c_depth - 1) begin : g_bad_af_offset
            $error("xilinx_distram_sync_fifo: ALMOST_FULL_OFFSET must be 1..DEPTH-1");
        end
        if (ALMOST_EMPTY_OFFSET < 1 || ALMOST_EMPTY_OFFSET > c_depth - 1) begin : g_bad_ae_offset
            $error("xilinx_distram_sync_fifo: ALMOST_EMPTY_OFFSET must be 1..DEPTH-1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and nets
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_do;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_we;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [c_prim_aw-1:0]  w_ram_a;
    logic [c_prim_aw-1:0]  w_ram_dpra;
    logic [DATA_WIDTH-1:0] w_dpo;

    // Requests are only honoured against the registered flags, so a write at
    // FULL is rejected even when a read frees a slot in the same cycle.
    assign w_wr_ok    = WREN & ~r_full;
    assign w_rd_ok    = RDEN & ~r_empty;
    // Reset wins: no RAM write may slip through while RST is high.
    assign w_we       = w_wr_ok & ~RST;
    assign w_ram_a    = c_prim_aw'(r_wptr);
    assign w_ram_dpra = c_prim_aw'(r_rptr);

    // ------------------------------------------------------------------------
    // Storage: one single-bit dual-port LUT RAM per data bit
    // ------------------------------------------------------------------------
    generate
        for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
            logic r_mem [c_prim_depth];

            // Port A: synchronous write of one data bit at the write pointer.
            always_ff @(posedge CLK) begin
                if (w_we) begin
                    r_mem[w_ram_a] <= DI[b];
                end
            end

            // DPRA/DPO: asynchronous read at the read pointer.
            assign w_dpo[b] = r_mem[w_ram_dpra];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control path
    // ------------------------------------------------------------------------
    // Next occupancy: simultaneous accepted read and write cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // Pointers, count, output register and flags (flags derived from the
    // next count so they line up with COUNT in the same cycle).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_do           <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
                r_do   <= w_dpo;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_full_cnt);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_af_thresh);
            r_almost_empty <= (w_count_nxt <= c_ae_thresh);
        end
    end

    assign DO          = r_do;
    assign FULL        = r_full;
    assign EMPTY       = r_empty;
    assign ALMOSTFULL  = r_almost_full;
    assign ALMOSTEMPTY = r_almost_empty;
    assign COUNT       = r_count;

`ifdef XILINX_DISTRAM_SYNC_FIFO_ERR_EN
    // ------------------------------------------------------------------------
    // Rejected-request pulses
    // ------------------------------------------------------------------------
    logic r_wrerr;
    logic r_rderr;

    // One-cycle, non-sticky pulses following a request that hit FULL/EMPTY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wrerr <= 1'b0;
            r_rderr <= 1'b0;
        end else begin
            r_wrerr <= WREN & r_full;
            r_rderr <= RDEN & r_empty;
        end
    end

    assign WRERR = r_wrerr;
    assign RDERR = r_rderr;
`endif

endmodule
`default_nettype wire

// File: doc/xilinx_distram_sync_fifo.md
Name: xilinx_distram_sync_fifo

Overview:
- Single-clock synchronous FIFO whose storage is a DATA_WIDTH-wide, 2^ADDR_WIDTH-deep dual-port distributed LUT RAM.
- Writes use the read/write port (A/D/WE); reads use the read-only port (DPRA/DPO), followed by one output register.
- Adds pointer management, occupancy count, full/empty/almost flags and a registered read path, none of which the bare dual-port RAM wrapper provides.
- Sits between producer and consumer logic in the same clock domain as a shallow, LUT-based elastic buffer.

Parameters:
- ADDR_WIDTH, 6, log2 of depth; legal 4..7. 4..5 maps to RAM32X1D (ADDR_WIDTH 4 ties address bit 4 to 0); 6 maps to RAM64X1D; 7 maps to RAM128X1D.
- DATA_WIDTH, 8, word width in bits; one RAM primitive per bit.
- ALMOST_FULL_OFFSET, 2, ALMOSTFULL asserts when COUNT >= DEPTH-ALMOST_FULL_OFFSET; legal 1..DEPTH-1.
- ALMOST_EMPTY_OFFSET, 2, ALMOSTEMPTY asserts when COUNT <= ALMOST_EMPTY_OFFSET; legal 1..DEPTH-1.
- Illegal values stop elaboration with $error.

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- RST  input  1  synchronous reset, active-high.
- DI  input  DATA_WIDTH  write data.
- WREN  input  1  write request.
- RDEN  input  1  read request.
- DO  output  DATA_WIDTH  registered read data.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- ALMOSTFULL  output  1  programmable almost-full flag.
- ALMOSTEMPTY  output  1  programmable almost-empty flag.
- COUNT  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- WRERR  output  1  present only with the optional feature.
- RDERR  output  1  present only with the optional feature.

Behaviour:
- DEPTH = 2^ADDR_WIDTH; the full DEPTH entries are usable.
- Reset: pointers = 0, COUNT = 0, EMPTY = 1, ALMOSTEMPTY = 1, FULL = 0, ALMOSTFULL = 0, DO = 0.
- RAM contents are not cleared. A reset mid-operation discards all stored words, because the pointers return to 0.
- RST has priority over WREN/RDEN in the same cycle.
- Write acceptance: wr_ok = WREN & ~FULL.
  - On wr_ok, the RAM WE pulses and DI is written at wptr.
  - wptr increments and wraps from DEPTH-1 to 0.
  - WREN while FULL=1 is ignored, even if a read is accepted in the same cycle.
- Read acceptance: rd_ok = RDEN & ~EMPTY.
  - On rd_ok, DO <= RAM[rptr] (DPO) at that clock edge, so data is valid the cycle after RDEN (latency 1).
  - rptr increments and wraps the same way as wptr.
  - RDEN while EMPTY=1 is ignored and DO holds its value.
  - DO holds its value in every cycle without rd_ok.
- A write to an empty FIFO is readable from the next cycle: EMPTY deasserts 1 cycle after the write, RDEN may then be taken, and the data appears on DO 1 cycle later. Write-to-DO minimum is 2 cycles.
- COUNT update:
  - +1 on wr_ok & ~rd_ok.
  - -1 on rd_ok & ~wr_ok.
  - Unchanged on both or neither.
- A simultaneous write and read with 0 < COUNT < DEPTH leaves COUNT unchanged; both operations complete.
- Flag timing: all flags are registered and computed from next-COUNT, so they are valid in the same cycle as COUNT with no extra lag.
- Invariants:
  - Never FULL & EMPTY together.
  - COUNT == (wptr - rptr) mod DEPTH, except that COUNT == DEPTH when FULL.

Optional Feature:
- Macro: XILINX_DISTRAM_SYNC_FIFO_ERR_EN.
- Defined:
  - WRERR and RDERR ports exist.
  - WRERR is registered, = WREN & FULL, and pulses one cycle after a rejected write.
  - RDERR is registered, = RDEN & EMPTY, and pulses one cycle after a rejected read.
  - Both clear on RST and are not sticky.
- Undefined: both ports and their logic are absent, and rejected requests are silently ignored.

Test Plan:
- Reset check: hold RST 3 cycles with WREN=RDEN=1 -> EMPTY=1, ALMOSTEMPTY=1, FULL=0, COUNT=0, DO=0 throughout; no write occurs.
- Fill and drain, ADDR_WIDTH=6, DATA_WIDTH=8: write 0x00..0x3F over 64 cycles, then read 64 -> FULL at COUNT=64; ALMOSTFULL from COUNT=62; DO sequence 0x00..0x3F, each 1 cycle after its RDEN; EMPTY after the last read.
- Overflow/underflow: WREN at FULL with 0xAA -> COUNT stays 64, no data corrupted, WRERR pulses (macro on). RDEN at EMPTY -> DO unchanged, RDERR pulses.
- Concurrent traffic: COUNT=5, then WREN=RDEN=1 for 200 cycles -> COUNT stays 5; pointers wrap three times; data order preserved against a reference queue.
- Edge cases: write one word into empty then immediately RDEN -> read ignored while EMPTY=1, accepted the next cycle. At FULL, WREN+RDEN together -> read taken, write rejected, COUNT=63.
- Sweep ADDR_WIDTH 4, 5, 7 with random WREN/RDEN at 50% for 10k cycles -> scoreboard match; flag and COUNT invariants hold every cycle; RST asserted mid-burst returns all outputs to reset values the next cycle.
